// File: rtl/hamming74_tx_ctrl.sv
// ----------------------------------------------------------------------------
// hamming74_tx_ctrl
//
// Sequencing controller for a serial-in Hamming(7,4) encoder. A 4-bit word is
// accepted over a valid/ready handshake and shifted MSB-first into the
// encoder. The resulting 7-bit codeword is captured and sent bit 6 first
// onto a 1-bit channel that can apply back-pressure through tx_ready.
//
// Optional feature macro: HAMMING_TX_PARITY_CHK_EN
//   When defined, the controller recomputes the parity bits from the accepted
//   word and flags any encoder disagreement on par_err (sticky until reset).
//   When undefined, no check logic exists and par_err is tied low.
//
// Parameters
//   CNT_W       width of the completed-codeword counter frame_cnt
//
// Ports
//   clk         clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   data_in     4-bit data word from the source
//   data_valid  source presents a word on data_in
//   data_ready  controller can accept a word (IDLE only)
//   enc_rst     active-high encoder reset, combinational ~reset
//   enc_in      serial bit into the encoder
//   enc_v       encoder codeword {p6,p5,p4,d3,d2,d1,d0}
//   tx_bit      serial channel bit
//   tx_valid    tx_bit is valid this cycle
//   tx_first    tx_bit is codeword bit 6 (frame start)
//   tx_ready    channel consumes tx_bit this cycle
//   busy        controller is not in IDLE
//   frame_cnt   completed codewords, wraps modulo 2^CNT_W
//   par_err     sticky parity self-check mismatch
// ----------------------------------------------------------------------------
module hamming74_tx_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             enc_rst,
    output logic             enc_in,
    input  logic [6:0]       enc_v,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_first,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             par_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CAPT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [3:0]       r_shreg;
    logic [1:0]       r_bitcnt;
    logic [6:0]       r_cw;
    logic [2:0]       r_txcnt;
    logic [CNT_W-1:0] r_frame_cnt;

    // The encoder must clear on the same edge as the controller.
    assign enc_rst   = ~reset;
    assign frame_cnt = r_frame_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (data_valid)       w_next = S_LOAD;
            S_LOAD: if (r_bitcnt == 2'd3) w_next = S_CAPT;
            S_CAPT:                       w_next = S_SEND;
            S_SEND: if (tx_ready && (r_txcnt == 3'd0)) w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only; tx_ready and data_valid
    // never reach an output combinationally.
    always_comb begin
        data_ready = 1'b0;
        enc_in     = 1'b0;
        tx_valid   = 1'b0;
        tx_bit     = 1'b0;
        tx_first   = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
            end
            S_LOAD: begin
                enc_in = r_shreg[3];
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_bit   = r_cw[r_txcnt];
                tx_first = (r_txcnt == 3'd6);
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg     <= 4'd0;
            r_bitcnt    <= 2'd0;
            r_cw        <= 7'd0;
            r_txcnt     <= 3'd0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_valid) begin
                        r_shreg  <= data_in;
                        r_bitcnt <= 2'd0;
                    end
                end
                S_LOAD: begin
                    r_shreg  <= {r_shreg[2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 2'd1;
                end
                S_CAPT: begin
                    // enc_v still shows the pre-edge codeword; the encoder's
                    // own shift on this edge is irrelevant from here on.
                    r_cw    <= enc_v;
                    r_txcnt <= 3'd6;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (r_txcnt == 3'd0) begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end else begin
                            r_txcnt <= r_txcnt - 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAMMING_TX_PARITY_CHK_EN
    // The shift register is emptied during LOAD, so the accepted word is kept
    // separately for the parity comparison in CAPT.
    logic [3:0] r_data;
    logic       r_par_err;

    function automatic logic [6:0] hamming_cw(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[1],
                d[3] ^ d[2] ^ d[0],
                d[2] ^ d[1] ^ d[0],
                d};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data    <= 4'd0;
            r_par_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && data_valid) begin
                r_data <= data_in;
            end
            if ((r_state == S_CAPT) && (enc_v != hamming_cw(r_data))) begin
                r_par_err <= 1'b1;
            end
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming74_tx_ctrl.sv
module tb_hamming74_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       data_valid;
    logic       tx_ready;
    logic [6:0] enc_v;

    logic       data_ready, enc_rst, enc_in, tx_bit, tx_valid, tx_first, busy, par_err;
    logic [7:0] frame_cnt;

    logic       data_ready2, enc_rst2, enc_in2, tx_bit2, tx_valid2, tx_first2, busy2, par_err2;
    logic [1:0] frame_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_frame;
    logic exp_par;
    logic exp_par_pre;

`ifdef HAMMING_TX_PARITY_CHK_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    hamming74_tx_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .enc_rst(enc_rst), .enc_in(enc_in), .enc_v(enc_v),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_first(tx_first), .tx_ready(tx_ready),
        .busy(busy), .frame_cnt(frame_cnt), .par_err(par_err)
    );

    // Narrow-counter instance driven in lockstep to exercise wrap-around.
    hamming74_tx_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready2), .enc_rst(enc_rst2), .enc_in(enc_in2), .enc_v(enc_v),
        .tx_bit(tx_bit2), .tx_valid(tx_valid2), .tx_first(tx_first2), .tx_ready(tx_ready),
        .busy(busy2), .frame_cnt(frame_cnt2), .par_err(par_err2)
    );

    // Serial-in encoder attached on the side, with an override for fault injection.
    logic [3:0] r_u;
    logic       stub_en;
    logic [6:0] stub_v;

    always @(posedge clk) begin
        if (enc_rst) r_u <= 4'd0;
        else         r_u <= {r_u[2:0], enc_in};
    end

    always_comb begin
        enc_v = {r_u[3] ^ r_u[2] ^ r_u[1], r_u[3] ^ r_u[2] ^ r_u[0], r_u[2] ^ r_u[1] ^ r_u[0], r_u};
        if (stub_en) enc_v = stub_v;
    end

    typedef struct {
        logic [3:0] word;
        logic [6:0] cw;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the controller is idle. Returns at the negedge
    // of the first idle cycle after the frame (cycle exp_idle).
    task automatic send_word(input logic [3:0] w, input logic [6:0] cw, input logic [63:0] stall,
                             input logic hold, input logic [3:0] nxt, input int exp_idle);
        int c;
        int i;
        chk("idle_ready", data_ready, 1);
        data_in    = w;
        data_valid = 1'b1;
        tx_ready   = 1'b1;
        tick();
        c = 1;
        if (hold) data_in = nxt;
        else      data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("load_enc_in", enc_in, w[3-k]);
            chk("load_ready", data_ready, 0);
            chk("load_txv", tx_valid, 0);
            tick();
            c++;
        end
        chk("capt_enc_in", enc_in, 0);
        chk("capt_txv", tx_valid, 0);
        chk("capt_par", par_err, exp_par_pre);
        tick();
        c++;
        i = 6;
        while (i >= 0 && c < 60) begin
            tx_ready = ~stall[c];
            chk("send_valid", tx_valid, 1);
            chk("send_bit", tx_bit, cw[i]);
            chk("send_first", tx_first, (i == 6));
            chk("send_ready", data_ready, 0);
            chk("send_par", par_err, exp_par);
            if (tx_ready) i--;
            tick();
            c++;
        end
        tx_ready = 1'b1;
        chk("send_done", (i < 0), 1);
        exp_frame++;
        chk("end_cycle", c, exp_idle);
        chk("end_ready", data_ready, 1);
        chk("end_txv", tx_valid, 0);
        chk("end_busy", busy, 0);
        chk("frame_cnt", frame_cnt, exp_frame[7:0]);
        chk("frame_cnt_w2", frame_cnt2, exp_frame[1:0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0110, 7'b0100110};
        vecs[1] = '{4'b1000, 7'b1101000};
        vecs[2] = '{4'b0101, 7'b1000101};
        vecs[3] = '{4'b0000, 7'b0000000};
        vecs[4] = '{4'b1111, 7'b1111111};

        reset       = 1'b0;
        data_in     = 4'd0;
        data_valid  = 1'b0;
        tx_ready    = 1'b1;
        stub_en     = 1'b0;
        stub_v      = 7'd0;
        exp_par     = 1'b0;
        exp_par_pre = 1'b0;
        exp_frame   = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", data_ready, 1);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txbit", tx_bit, 0);
        chk("rst_first", tx_first, 0);
        chk("rst_enc_in", enc_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_par", par_err, 0);
        chk("rst_enc_rst", enc_rst, 1);
        reset = 1'b1;
        #1;
        chk("run_enc_rst", enc_rst, 0);
        @(negedge clk);

        // Reset in the middle of SEND aborts the frame
        data_in    = 4'b0110;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (7) tick();
        chk("abort_in_send", tx_valid, 1);
        reset = 1'b0;
        #1;
        chk("abort_enc_rst", enc_rst, 1);
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_txv", tx_valid, 0);
        chk("abort_ready", data_ready, 1);
        chk("abort_frame", frame_cnt, 0);
        reset = 1'b1;
        #1;

        // Fresh word after the abort completes normally
        send_word(4'b1011, 7'b0001011, 64'd0, 1'b0, 4'd0, 13);

        // Table of words
        for (int n = 0; n < 5; n++) begin
            send_word(vecs[n].word, vecs[n].cw, 64'd0, 1'b0, 4'd0, 13);
        end

        // Back-to-back with data_valid held: second accept in cycle 13
        send_word(4'b0001, 7'b0110001, 64'd0, 1'b1, 4'b1111, 13);
        send_word(4'b1111, 7'b1111111, 64'd0, 1'b0, 4'd0, 13);

        // tx_ready low in cycles 7 and 8
        send_word(4'b0001, 7'b0110001, 64'h180, 1'b0, 4'd0, 15);

        // Faulty encoder: codeword transmitted as captured, parity flag sticky
        stub_v      = 7'b0000001;
        stub_en     = 1'b1;
        exp_par_pre = 1'b0;
        exp_par     = PAR_EXP;
        send_word(4'b0001, 7'b0000001, 64'd0, 1'b0, 4'd0, 13);
        stub_en     = 1'b0;
        exp_par_pre = PAR_EXP;
        send_word(4'b1011, 7'b0001011, 64'd0, 1'b0, 4'd0, 13);

        // Reset clears the sticky flag and the counter
        reset = 1'b0;
        tick();
        chk("final_rst_par", par_err, 0);
        chk("final_rst_frame", frame_cnt, 0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
